// File: rtl/opcode_arbiter.sv
// N-channel draw-opcode arbiter with round-robin / fixed-priority grant
// and a source-tagged FIFO in front of the sprite engine.
module opcode_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_W     = 2,
  parameter int ID_W       = 2,
  parameter int COORD_W    = 9,
  parameter int FIFO_DEPTH = 4,
  parameter int CH_W       = $clog2(NUM_CH),
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      PRIO_MODE,
  input  logic                      FLUSH,
  input  logic [NUM_CH-1:0]         REQ_VALID,
  output logic [NUM_CH-1:0]         REQ_READY,
  input  logic [NUM_CH*ADDR_W-1:0]  ADDR_IN,
  input  logic [NUM_CH*ID_W-1:0]    ID_CODE_IN,
  input  logic [NUM_CH*COORD_W-1:0] X_IN,
  input  logic [NUM_CH*COORD_W-1:0] Y_IN,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [ADDR_W-1:0]         ADDR_OUT,
  output logic [ID_W-1:0]           ID_CODE_OUT,
  output logic [COORD_W-1:0]        X_OUT,
  output logic [COORD_W-1:0]        Y_OUT,
  output logic [CH_W-1:0]           CH_OUT,
  output logic [CNT_W-1:0]          COUNT
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int E_W   = ADDR_W + ID_W + 2 * COORD_W + CH_W;

  logic [E_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  gnt_idx;
  logic             gnt_any;
  logic             gnt_ok;
  logic             push;
  logic             pop;
  logic [E_W-1:0]   entry;
  logic [E_W-1:0]   head;

  // Rotating search; base 0 makes it a plain lowest-index priority encoder
  always_comb begin
    logic [CH_W-1:0] base;
    logic [CH_W:0]   sum;
    logic [CH_W-1:0] sel;
    gnt_any = 1'b0;
    gnt_idx = '0;
    base    = PRIO_MODE ? '0 : rr_ptr;
    sum     = '0;
    sel     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = {1'b0, base} + (CH_W + 1)'(k);
      if (sum >= (CH_W + 1)'(NUM_CH))
        sum = sum - (CH_W + 1)'(NUM_CH);
      sel = sum[CH_W-1:0];
      if (!gnt_any && REQ_VALID[sel]) begin
        gnt_any = 1'b1;
        gnt_idx = sel;
      end
    end
  end

  assign gnt_ok = gnt_any && !Reset && !FLUSH &&
                  (COUNT < CNT_W'(FIFO_DEPTH));

  always_comb begin
    REQ_READY = '0;
    if (gnt_ok)
      REQ_READY[gnt_idx] = 1'b1;
  end

  assign push = gnt_ok;
  assign pop  = OUT_VALID && OUT_READY && !FLUSH;

  assign entry = {ADDR_IN[gnt_idx*ADDR_W +: ADDR_W],
                  ID_CODE_IN[gnt_idx*ID_W +: ID_W],
                  X_IN[gnt_idx*COORD_W +: COORD_W],
                  Y_IN[gnt_idx*COORD_W +: COORD_W],
                  gnt_idx};

  always_ff @(posedge Clk) begin
    if (push)
      mem[wptr] <= entry;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wptr   <= '0;
      rptr   <= '0;
      rr_ptr <= '0;
      COUNT  <= '0;
    end else if (FLUSH) begin
      wptr   <= '0;
      rptr   <= '0;
      rr_ptr <= '0;
      COUNT  <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
        if (!PRIO_MODE)
          rr_ptr <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (pop)
        rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   COUNT <= COUNT + 1'b1;
        2'b01:   COUNT <= COUNT - 1'b1;
        default: COUNT <= COUNT;
      endcase
    end
  end

  assign OUT_VALID = (COUNT != '0);
  assign head      = OUT_VALID ? mem[rptr] : '0;
  assign {ADDR_OUT, ID_CODE_OUT, X_OUT, Y_OUT, CH_OUT} = head;

endmodule

// File: tb/tb_opcode_arbiter.sv
// Directed bench for opcode_arbiter: handshake, arbitration modes,
// backpressure, flush and asynchronous reset.
module tb_opcode_arbiter;

  logic        Clk;
  logic        Reset;
  logic        PRIO_MODE;
  logic        FLUSH;
  logic [3:0]  REQ_VALID;
  logic [3:0]  REQ_READY;
  logic [7:0]  ADDR_IN;
  logic [7:0]  ID_CODE_IN;
  logic [35:0] X_IN;
  logic [35:0] Y_IN;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [1:0]  ADDR_OUT;
  logic [1:0]  ID_CODE_OUT;
  logic [8:0]  X_OUT;
  logic [8:0]  Y_OUT;
  logic [1:0]  CH_OUT;
  logic [2:0]  COUNT;

  int checks = 0;
  int passed = 0;

  opcode_arbiter dut (
    .Clk(Clk), .Reset(Reset), .PRIO_MODE(PRIO_MODE), .FLUSH(FLUSH),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .ADDR_IN(ADDR_IN), .ID_CODE_IN(ID_CODE_IN),
    .X_IN(X_IN), .Y_IN(Y_IN),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .ADDR_OUT(ADDR_OUT), .ID_CODE_OUT(ID_CODE_OUT),
    .X_OUT(X_OUT), .Y_OUT(Y_OUT), .CH_OUT(CH_OUT), .COUNT(COUNT)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required $finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [1:0] a,
                        input logic [1:0] id, input logic [8:0] x,
                        input logic [8:0] y);
    ADDR_IN[ch*2 +: 2]    = a;
    ID_CODE_IN[ch*2 +: 2] = id;
    X_IN[ch*9 +: 9]       = x;
    Y_IN[ch*9 +: 9]       = y;
  endtask

  task automatic do_flush();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    REQ_VALID = 4'b1111;
    #1;
    checks++;
    if (REQ_READY !== 4'b0000)
      $display("FAIL reset_ready: got %b want 0000", REQ_READY);
    else passed++;
    tick();
    checks++;
    if (COUNT !== 3'd0 || OUT_VALID !== 1'b0 || X_OUT !== 9'd0 ||
        CH_OUT !== 2'd0)
      $display("FAIL reset_state: count=%0d valid=%b x=%0d ch=%0d want 0",
               COUNT, OUT_VALID, X_OUT, CH_OUT);
    else passed++;
    REQ_VALID = 4'b0000;
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    OUT_READY = 1'b1;
    set_ch(2, 2'd1, 2'd3, 9'd100, 9'd50);
    REQ_VALID = 4'b0100;
    #1;
    checks++;
    if (REQ_READY !== 4'b0100)
      $display("FAIL single_ready: got %b want 0100", REQ_READY);
    else passed++;
    tick();
    REQ_VALID = 4'b0000;
    #1;
    checks++;
    if (OUT_VALID !== 1'b1 || ADDR_OUT !== 2'd1 || ID_CODE_OUT !== 2'd3 ||
        X_OUT !== 9'd100 || Y_OUT !== 9'd50 || CH_OUT !== 2'd2 ||
        COUNT !== 3'd1)
      $display("FAIL single_head: got v=%b %0d/%0d/%0d/%0d ch=%0d cnt=%0d want 1 1/3/100/50 ch=2 cnt=1",
               OUT_VALID, ADDR_OUT, ID_CODE_OUT, X_OUT, Y_OUT, CH_OUT, COUNT);
    else passed++;
    tick();
    checks++;
    if (OUT_VALID !== 1'b0 || COUNT !== 3'd0 || X_OUT !== 9'd0)
      $display("FAIL single_empty: v=%b cnt=%0d x=%0d want 0/0/0",
               OUT_VALID, COUNT, X_OUT);
    else passed++;
  endtask

  task automatic test_round_robin();
    int exp_ch;
    do_flush();
    OUT_READY = 1'b1;
    PRIO_MODE = 1'b0;
    for (int c = 0; c < 4; c++)
      set_ch(c, 2'(c), 2'(3 - c), 9'(10 + c), 9'(20 + c));
    REQ_VALID = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      exp_ch = i % 4;
      #1;
      checks++;
      if (REQ_READY !== (4'b0001 << exp_ch))
        $display("FAIL rr_grant[%0d]: got %b want ch%0d", i, REQ_READY, exp_ch);
      else passed++;
      tick();
      checks++;
      if (CH_OUT !== 2'(exp_ch) || X_OUT !== 9'(10 + exp_ch) ||
          COUNT !== 3'd1)
        $display("FAIL rr_out[%0d]: ch=%0d x=%0d cnt=%0d want ch=%0d x=%0d cnt=1",
                 i, CH_OUT, X_OUT, COUNT, exp_ch, 10 + exp_ch);
      else passed++;
    end
    REQ_VALID = 4'b0000;
    tick();
  endtask

  task automatic test_priority();
    REQ_VALID = 4'b1010;
    #1;
    checks++;
    if (REQ_READY !== 4'b1000)
      $display("FAIL rr_from_ptr2: got %b want 1000", REQ_READY);
    else passed++;
    PRIO_MODE = 1'b1;
    #1;
    checks++;
    if (REQ_READY !== 4'b0010)
      $display("FAIL prio_switch: got %b want 0010", REQ_READY);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (REQ_READY !== 4'b0010 || CH_OUT !== 2'd1)
        $display("FAIL prio_hold[%0d]: ready=%b ch=%0d want 0010 ch=1",
                 i, REQ_READY, CH_OUT);
      else passed++;
    end
    REQ_VALID = 4'b1000;
    #1;
    checks++;
    if (REQ_READY !== 4'b1000)
      $display("FAIL prio_starve_end: got %b want 1000", REQ_READY);
    else passed++;
    tick();
    REQ_VALID = 4'b0000;
    PRIO_MODE = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    do_flush();
    OUT_READY = 1'b0;
    REQ_VALID = 4'b0001;
    for (int k = 1; k <= 4; k++) begin
      set_ch(0, 2'd0, 2'd0, 9'(k), 9'd0);
      #1;
      checks++;
      if (REQ_READY !== 4'b0001)
        $display("FAIL fill[%0d]: got %b want 0001", k, REQ_READY);
      else passed++;
      tick();
    end
    set_ch(0, 2'd0, 2'd0, 9'd5, 9'd0);
    #1;
    checks++;
    if (REQ_READY !== 4'b0000 || COUNT !== 3'd4)
      $display("FAIL full: ready=%b cnt=%0d want 0000 4", REQ_READY, COUNT);
    else passed++;
    OUT_READY = 1'b1;
    #1;
    checks++;
    if (REQ_READY !== 4'b0000 || X_OUT !== 9'd1)
      $display("FAIL full_pop_same: ready=%b x=%0d want 0000 1",
               REQ_READY, X_OUT);
    else passed++;
    tick();
    for (int h = 2; h <= 3; h++) begin
      set_ch(0, 2'd0, 2'd0, 9'(h + 3), 9'd0);
      #1;
      checks++;
      if (REQ_READY !== 4'b0001 || X_OUT !== 9'(h) || COUNT !== 3'd3)
        $display("FAIL refill[%0d]: ready=%b x=%0d cnt=%0d want 0001 %0d 3",
                 h, REQ_READY, X_OUT, COUNT, h);
      else passed++;
      tick();
    end
    REQ_VALID = 4'b0000;
    for (int h = 4; h <= 6; h++) begin
      checks++;
      if (X_OUT !== 9'(h) || OUT_VALID !== 1'b1)
        $display("FAIL drain[%0d]: x=%0d v=%b want %0d 1", h, X_OUT,
                 OUT_VALID, h);
      else passed++;
      tick();
    end
    checks++;
    if (OUT_VALID !== 1'b0 || COUNT !== 3'd0)
      $display("FAIL drained: v=%b cnt=%0d want 0 0", OUT_VALID, COUNT);
    else passed++;
  endtask

  task automatic test_flush();
    OUT_READY = 1'b0;
    set_ch(1, 2'd3, 2'd2, 9'd511, 9'd0);
    REQ_VALID = 4'b0010;
    repeat (4) tick();
    checks++;
    if (COUNT !== 3'd4 || X_OUT !== 9'd511 || Y_OUT !== 9'd0 ||
        CH_OUT !== 2'd1 || ADDR_OUT !== 2'd3)
      $display("FAIL flush_full: cnt=%0d x=%0d y=%0d ch=%0d a=%0d want 4 511 0 1 3",
               COUNT, X_OUT, Y_OUT, CH_OUT, ADDR_OUT);
    else passed++;
    OUT_READY = 1'b1;
    FLUSH = 1'b1;
    #1;
    checks++;
    if (REQ_READY !== 4'b0000)
      $display("FAIL flush_ready: got %b want 0000", REQ_READY);
    else passed++;
    tick();
    FLUSH = 1'b0;
    REQ_VALID = 4'b1111;
    #1;
    checks++;
    if (COUNT !== 3'd0 || OUT_VALID !== 1'b0 || REQ_READY !== 4'b0001)
      $display("FAIL flush_clear: cnt=%0d v=%b ready=%b want 0 0 0001",
               COUNT, OUT_VALID, REQ_READY);
    else passed++;
    OUT_READY = 1'b0;
    set_ch(3, 2'd2, 2'd1, 9'd7, 9'd8);
    REQ_VALID = 4'b1000;
    tick();
    REQ_VALID = 4'b0000;
    checks++;
    if (COUNT !== 3'd1 || X_OUT !== 9'd7 || Y_OUT !== 9'd8 || CH_OUT !== 2'd3)
      $display("FAIL flush_next: cnt=%0d x=%0d y=%0d ch=%0d want 1 7 8 3",
               COUNT, X_OUT, Y_OUT, CH_OUT);
    else passed++;
  endtask

  task automatic test_async_reset();
    do_flush();
    OUT_READY = 1'b0;
    set_ch(0, 2'd1, 2'd1, 9'd33, 9'd44);
    REQ_VALID = 4'b0001;
    repeat (3) tick();
    checks++;
    if (COUNT !== 3'd3 || X_OUT !== 9'd33)
      $display("FAIL pre_reset: cnt=%0d x=%0d want 3 33", COUNT, X_OUT);
    else passed++;
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if (COUNT !== 3'd0 || OUT_VALID !== 1'b0 || X_OUT !== 9'd0 ||
        Y_OUT !== 9'd0 || ADDR_OUT !== 2'd0 || REQ_READY !== 4'b0000)
      $display("FAIL async_reset: cnt=%0d v=%b x=%0d y=%0d a=%0d ready=%b want zeros",
               COUNT, OUT_VALID, X_OUT, Y_OUT, ADDR_OUT, REQ_READY);
    else passed++;
    REQ_VALID = 4'b0000;
    tick();
    Reset = 1'b0;
    tick();
  endtask

  initial begin
    Reset = 1'b1;
    PRIO_MODE = 1'b0;
    FLUSH = 1'b0;
    REQ_VALID = '0;
    OUT_READY = 1'b0;
    ADDR_IN = '0;
    ID_CODE_IN = '0;
    X_IN = '0;
    Y_IN = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/opcode_arbiter.md
Name: opcode_arbiter

Overview:
- Parametrised N-channel successor to the two-input sprite opcode select: collects draw opcodes (ADDR, ID_CODE, X, Y) from NUM_CH independent producers over valid/ready handshakes.
- Arbitrates between producers in round-robin or fixed-priority mode and queues the winners in a FIFO in front of the sprite drawing engine.
- Tags each queued opcode with its source channel and supports a synchronous per-frame flush.

Parameters:
- NUM_CH, 4, number of requesting channels (>=2).
- ADDR_W, 2, opcode address width.
- ID_W, 2, sprite ID code width.
- COORD_W, 9, X/Y coordinate width.
- FIFO_DEPTH, 4, output queue entries (power of two, >=2).
- CH_W, $clog2(NUM_CH), channel index width (derived).
- CNT_W, $clog2(FIFO_DEPTH+1), occupancy width (derived).

Ports:
- Clk  input  1  system clock, all state on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- PRIO_MODE  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- FLUSH  input  1  synchronous queue clear (frame start).
- REQ_VALID  input  NUM_CH  per-channel opcode valid.
- REQ_READY  output  NUM_CH  per-channel accept (one-hot or zero).
- ADDR_IN  input  NUM_CH*ADDR_W  packed; channel i at [i*ADDR_W +: ADDR_W].
- ID_CODE_IN  input  NUM_CH*ID_W  packed, same layout.
- X_IN  input  NUM_CH*COORD_W  packed, same layout.
- Y_IN  input  NUM_CH*COORD_W  packed, same layout.
- OUT_VALID  output  1  queue head valid.
- OUT_READY  input  1  consumer accepts head.
- ADDR_OUT  output  ADDR_W  head address.
- ID_CODE_OUT  output  ID_W  head ID code.
- X_OUT  output  COORD_W  head X.
- Y_OUT  output  COORD_W  head Y.
- CH_OUT  output  CH_W  source channel of head.
- COUNT  output  CNT_W  FIFO occupancy.

Behaviour:
- Reset (async assert): FIFO empty, COUNT=0, OUT_VALID=0, all data outputs and CH_OUT = 0, RR pointer = 0, write/read pointers = 0. REQ_READY=0 while Reset is high.
- Grant (combinational): grant only when COUNT<FIFO_DEPTH and FLUSH=0, else REQ_READY=0.
  - Round-robin: first channel with REQ_VALID set, searching from RR pointer upward with wrap.
  - Fixed priority: lowest-index channel with REQ_VALID set.
  - REQ_READY is one-hot on the granted channel and never depends on OUT_READY (no full-queue pass-through).
- Push: on REQ_VALID[g]&REQ_READY[g], store {ADDR, ID, X, Y, g} at the write pointer.
  - In round-robin mode the RR pointer becomes (g+1) mod NUM_CH; no grant leaves it unchanged.
  - Fixed-priority mode never updates the RR pointer.
- Pop: on OUT_VALID&OUT_READY the read pointer advances.
  - OUT_VALID = (COUNT!=0).
  - Data outputs show the head entry when OUT_VALID=1 and are forced to 0 when empty.
- Latency: an opcode accepted at edge N appears on the outputs after edge N. No empty-queue bypass.
- Simultaneous push and pop: COUNT unchanged, both pointers advance. When full, a pop frees a slot only from the next cycle.
- Pointer wrap: write/read pointers wrap modulo FIFO_DEPTH. Ordering is strict FIFO.
- FLUSH=1 at an edge: COUNT=0, pointers=0, RR pointer=0. A pop or push in the same cycle is discarded (REQ_READY is already 0).
- Producers must hold data stable while REQ_VALID=1 and REQ_READY=0. The block does not check this.
- PRIO_MODE may change any cycle and takes effect on the same cycle's grant.
- Reset asserted mid-transfer discards all queued opcodes. No partial entry is ever visible.

Test Plan:
- Reset, then ch2 sends {ADDR=1, ID=3, X=100, Y=50} with OUT_READY=1 -> REQ_READY=0100, next cycle OUT_VALID=1, outputs 1/3/100/50, CH_OUT=2, COUNT=1, then empties.
- Round-robin, all 4 channels valid continuously, OUT_READY=1 -> grants 0,1,2,3,0,1 on consecutive cycles, and CH_OUT follows one cycle later.
- PRIO_MODE=1, ch1 and ch3 valid continuously -> ch1 granted every cycle; ch3 starves until ch1 drops valid.
- OUT_READY=0, ch0 sends 6 opcodes X=1..6 -> first 4 accepted, COUNT=4, REQ_READY=0. Raising OUT_READY pops X=1,2,3,4 in order while ch0 refills X=5,6 with no loss or reorder.
- Queue full with X=511 and Y=0 boundary values, FLUSH pulsed for one cycle -> COUNT=0, OUT_VALID=0 next cycle, RR pointer=0. The next push is accepted normally.
- Reset asserted asynchronously mid-burst with COUNT=3 -> OUT_VALID, COUNT and outputs go to 0 immediately, before the next Clk edge.
